// File: rtl/exec_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_ctrl_unit_if
//  Description : Execute/control slice bundle. Carries instruction fields and
//                operands in, and decoded controls, ALU result, branch
//                decision and registered debug copies out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_ctrl_unit_if #(
  parameter int XLEN = 32
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;

  logic [1:0]      alu_op;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            alu_src;
  logic            mem_to_reg;
  logic            branch;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            branch_taken;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  // Instruction/operand source side (decoder, regfile, imm_gen)
  modport master (
    output opcode, funct3, funct7, rs1_data, rs2_data, imm,
    input  alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg,
           branch, alu_ctrl, alu_result, zero, branch_taken, result_q, zero_q
  );

  // Execute/control slice side
  modport slave (
    input  opcode, funct3, funct7, rs1_data, rs2_data, imm,
    output alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg,
           branch, alu_ctrl, alu_result, zero, branch_taken, result_q, zero_q
  );
endinterface
`default_nettype wire

// File: rtl/exec_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_ctrl_unit
//  Description : RV32I single-cycle execute/control slice: main opcode
//                decoder, ALU-operation decoder, 32-bit ALU with operand-B
//                mux and branch decision. All of that is combinational; only
//                result_q/zero_q are registered (trace/debug copy).
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl_unit #(
  parameter int XLEN = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  exec_ctrl_unit_if.slave   bus
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_XOR  = 4'b0011;
  localparam logic [3:0] c_ALU_SLL  = 4'b0100;
  localparam logic [3:0] c_ALU_SRL  = 4'b0101;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SRA  = 4'b0111;
  localparam logic [3:0] c_ALU_SLT  = 4'b1000;
  localparam logic [3:0] c_ALU_SLTU = 4'b1001;

  logic [1:0]      w_alu_op;
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_alu_src;
  logic            w_mem_to_reg;
  logic            w_branch;
  logic [3:0]      w_alu_ctrl;
  logic [XLEN-1:0] w_op_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_result;
  logic            w_zero;
  logic            w_taken;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  // Main control: opcode to datapath control signals; unknown opcodes are inert
  always_comb begin
    w_alu_op     = 2'b00;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    case (bus.opcode)
      c_OP_R: begin
        w_alu_op    = 2'b10;
        w_reg_write = 1'b1;
      end
      c_OP_I: begin
        w_alu_op    = 2'b11;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      c_OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      c_OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      c_OP_BRANCH: begin
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU-operation decode; I-type funct3=000 is always ADD because funct7 bits
  // there belong to the immediate, but srai/srli still rely on funct7[5]
  always_comb begin
    w_alu_ctrl = c_ALU_ADD;
    case (w_alu_op)
      2'b00: w_alu_ctrl = c_ALU_ADD;
      2'b01: w_alu_ctrl = c_ALU_SUB;
      default: begin
        case (bus.funct3)
          3'b000: w_alu_ctrl = (w_alu_op == 2'b10 && bus.funct7[5]) ? c_ALU_SUB : c_ALU_ADD;
          3'b001: w_alu_ctrl = c_ALU_SLL;
          3'b010: w_alu_ctrl = c_ALU_SLT;
          3'b011: w_alu_ctrl = c_ALU_SLTU;
          3'b100: w_alu_ctrl = c_ALU_XOR;
          3'b101: w_alu_ctrl = bus.funct7[5] ? c_ALU_SRA : c_ALU_SRL;
          3'b110: w_alu_ctrl = c_ALU_OR;
          default: w_alu_ctrl = c_ALU_AND;
        endcase
      end
    endcase
  end

  assign w_op_b  = w_alu_src ? bus.imm : bus.rs2_data;
  assign w_shamt = w_op_b[4:0];

  // ALU datapath; reserved alu_ctrl codes yield zero
  always_comb begin
    w_result = '0;
    case (w_alu_ctrl)
      c_ALU_AND:  w_result = bus.rs1_data & w_op_b;
      c_ALU_OR:   w_result = bus.rs1_data | w_op_b;
      c_ALU_ADD:  w_result = bus.rs1_data + w_op_b;
      c_ALU_XOR:  w_result = bus.rs1_data ^ w_op_b;
      c_ALU_SLL:  w_result = bus.rs1_data << w_shamt;
      c_ALU_SRL:  w_result = bus.rs1_data >> w_shamt;
      c_ALU_SUB:  w_result = bus.rs1_data - w_op_b;
      c_ALU_SRA:  w_result = $unsigned($signed(bus.rs1_data) >>> w_shamt);
      c_ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(bus.rs1_data) < $signed(w_op_b))};
      c_ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (bus.rs1_data < w_op_b)};
      default:    w_result = '0;
    endcase
  end

  assign w_zero  = (w_result == '0);
  // Only BEQ/BNE are resolved here; other branch funct3 values never take
  assign w_taken = w_branch && (((bus.funct3 == 3'b000) && w_zero) ||
                                ((bus.funct3 == 3'b001) && !w_zero));

  // Debug copy of result/zero, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_result <= w_result;
      r_zero   <= w_zero;
    end
  end

  assign bus.alu_op       = w_alu_op;
  assign bus.reg_write    = w_reg_write;
  assign bus.mem_read     = w_mem_read;
  assign bus.mem_write    = w_mem_write;
  assign bus.alu_src      = w_alu_src;
  assign bus.mem_to_reg   = w_mem_to_reg;
  assign bus.branch       = w_branch;
  assign bus.alu_ctrl     = w_alu_ctrl;
  assign bus.alu_result   = w_result;
  assign bus.zero         = w_zero;
  assign bus.branch_taken = w_taken;
  assign bus.result_q     = r_result;
  assign bus.zero_q       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_ctrl_unit
//  Description : Directed self-checking bench for exec_ctrl_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_ctrl_unit;

  localparam logic [6:0] c_R   = 7'b0110011;
  localparam logic [6:0] c_I   = 7'b0010011;
  localparam logic [6:0] c_LD  = 7'b0000011;
  localparam logic [6:0] c_ST  = 7'b0100011;
  localparam logic [6:0] c_BR  = 7'b1100011;
  localparam logic [6:0] c_UNK = 7'b1111111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  exec_ctrl_unit_if #(.XLEN(32)) bus ();

  exec_ctrl_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.imm      = im;
    #1;
  endtask

  // ctl packs {alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch}
  task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im, input logic [7:0] ctl, input logic [3:0] actl,
                     input logic [31:0] res, input logic zr, input logic tk);
    logic [7:0] got_ctl;
    drive(op, f3, f7, a, b, im);
    got_ctl = {bus.alu_op, bus.reg_write, bus.mem_read, bus.mem_write,
               bus.alu_src, bus.mem_to_reg, bus.branch};
    check_val({tag, ".ctl"},   {24'd0, got_ctl}, {24'd0, ctl});
    check_val({tag, ".actl"},  {28'd0, bus.alu_ctrl}, {28'd0, actl});
    check_val({tag, ".res"},   bus.alu_result, res);
    check_val({tag, ".zero"},  {31'd0, bus.zero}, {31'd0, zr});
    check_val({tag, ".taken"}, {31'd0, bus.branch_taken}, {31'd0, tk});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    drive(c_UNK, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_val("rst.result_q", bus.result_q, 32'd0);
    check_val("rst.zero_q",   {31'd0, bus.zero_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type sub, then registered copy one edge later
    @(negedge clk);
    vec("rsub", c_R, 3'b000, 7'b0100000, 32'd7, 32'd7, 32'd0, 8'b10100000, 4'b0110, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_val("rsub.result_q", bus.result_q, 32'd0);
    check_val("rsub.zero_q",   {31'd0, bus.zero_q}, 32'd1);

    @(negedge clk);
    vec("addi",  c_I,  3'b000, 7'b1111111, 32'd5,      32'd9,  32'hFFFFFFFF, 8'b11100100, 4'b0010, 32'd4,      1'b0, 1'b0);
    vec("load",  c_LD, 3'b010, 7'd0,       32'h100,    32'h55, 32'd8,        8'b00110110, 4'b0010, 32'h108,    1'b0, 1'b0);
    vec("store", c_ST, 3'b010, 7'd0,       32'h100,    32'h55, 32'd8,        8'b00001100, 4'b0010, 32'h108,    1'b0, 1'b0);
    vec("beq_t", c_BR, 3'b000, 7'd0,       32'd3,      32'd3,  32'd0,        8'b01000001, 4'b0110, 32'd0,      1'b1, 1'b1);
    vec("beq_n", c_BR, 3'b000, 7'd0,       32'd3,      32'd4,  32'd0,        8'b01000001, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
    vec("bne_t", c_BR, 3'b001, 7'd0,       32'd3,      32'd4,  32'd0,        8'b01000001, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b1);
    vec("bne_n", c_BR, 3'b001, 7'd0,       32'd3,      32'd3,  32'd0,        8'b01000001, 4'b0110, 32'd0,      1'b1, 1'b0);
    vec("blt_x", c_BR, 3'b100, 7'd0,       32'd3,      32'd3,  32'd0,        8'b01000001, 4'b0110, 32'd0,      1'b1, 1'b0);
    vec("sra",   c_R,  3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'd0,       8'b10100000, 4'b0111, 32'hF8000000, 1'b0, 1'b0);
    vec("srl",   c_R,  3'b101, 7'd0,       32'h80000000, 32'd4, 32'd0,       8'b10100000, 4'b0101, 32'h08000000, 1'b0, 1'b0);
    vec("slt",   c_R,  3'b010, 7'd0,       32'hFFFFFFFF, 32'd1, 32'd0,       8'b10100000, 4'b1000, 32'd1,      1'b0, 1'b0);
    vec("sltu",  c_R,  3'b011, 7'd0,       32'hFFFFFFFF, 32'd1, 32'd0,       8'b10100000, 4'b1001, 32'd0,      1'b1, 1'b0);
    vec("sll",   c_R,  3'b001, 7'd0,       32'd1,      32'h24, 32'd0,        8'b10100000, 4'b0100, 32'h10,     1'b0, 1'b0);
    vec("srai",  c_I,  3'b101, 7'b0100000, 32'h80000000, 32'd0, 32'h404,     8'b11100100, 4'b0111, 32'hF8000000, 1'b0, 1'b0);
    vec("srli",  c_I,  3'b101, 7'd0,       32'h80000000, 32'd0, 32'd4,       8'b11100100, 4'b0101, 32'h08000000, 1'b0, 1'b0);
    vec("radd",  c_R,  3'b000, 7'd0,       32'd7,      32'd7,  32'd0,        8'b10100000, 4'b0010, 32'd14,     1'b0, 1'b0);
    vec("xor",   c_R,  3'b100, 7'd0,       32'hF0F0,   32'h0FF0, 32'd0,      8'b10100000, 4'b0011, 32'hFF00,   1'b0, 1'b0);
    vec("or",    c_R,  3'b110, 7'd0,       32'hF0F0,   32'h0FF0, 32'd0,      8'b10100000, 4'b0001, 32'hFFF0,   1'b0, 1'b0);
    vec("and",   c_R,  3'b111, 7'd0,       32'hF0F0,   32'h0FF0, 32'd0,      8'b10100000, 4'b0000, 32'h00F0,   1'b0, 1'b0);
    vec("wrap",  c_R,  3'b000, 7'd0,       32'hFFFFFFFF, 32'd1, 32'd0,       8'b10100000, 4'b0010, 32'd0,      1'b1, 1'b0);
    vec("unk",   c_UNK, 3'b000, 7'd0,      32'd0,      32'd0,  32'd0,        8'b00000000, 4'b0010, 32'd0,      1'b1, 1'b0);

    // Capture 0x1234, then async reset between edges clears result_q
    vec("cap1234", c_I, 3'b000, 7'd0, 32'h1234, 32'd0, 32'd0, 8'b11100100, 4'b0010, 32'h1234, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("cap.result_q", bus.result_q, 32'h1234);
    check_val("cap.zero_q",   {31'd0, bus.zero_q}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("arst.result_q", bus.result_q, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Capture zero=1, then async reset clears zero_q and holds through an edge
    drive(c_R, 3'b000, 7'b0100000, 32'd9, 32'd9, 32'd0);
    @(posedge clk); #1;
    check_val("capz.zero_q", {31'd0, bus.zero_q}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst.zero_q", {31'd0, bus.zero_q}, 32'd0);
    drive(c_R, 3'b000, 7'd0, 32'd2, 32'd3, 32'd0);
    check_val("rst.comb_tracks", bus.alu_result, 32'd5);
    @(posedge clk); #1;
    check_val("hold.result_q", bus.result_q, 32'd0);
    check_val("hold.zero_q",   {31'd0, bus.zero_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("resume.result_q", bus.result_q, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_ctrl_unit.md
Name: exec_ctrl_unit

Overview:
- Execute/control slice of the single-cycle RV32I core. It merges three functions:
  - main opcode decoder (`control`);
  - ALU-operation decoder (`alu_control`);
  - 32-bit ALU with its operand-B source mux.
- Sits between decoder/regfile/imm_gen and data memory, writeback mux and PC-next logic.
- Decoded controls, ALU result, zero flag and branch decision are combinational, for same-cycle use.
- A registered copy of result and zero is provided for trace/debug.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset; clears only the registered outputs.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- rs1_data  in  32  ALU operand A.
- rs2_data  in  32  operand B when alu_src=0.
- imm  in  32  sign-extended immediate; operand B when alu_src=1.
- alu_op  out  2  00 = add, 01 = sub/branch, 10 = R-type, 11 = I-type ALU.
- reg_write  out  1  regfile write enable.
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable.
- alu_src  out  1  1 selects imm as operand B.
- mem_to_reg  out  1  1 selects memory data for writeback.
- branch  out  1  instruction is a conditional branch.
- alu_ctrl  out  4  decoded ALU operation.
- alu_result  out  32  combinational ALU result.
- zero  out  1  alu_result == 0.
- branch_taken  out  1  branch decision for the PC mux.
- result_q  out  32  alu_result registered on clk.
- zero_q  out  1  zero registered on clk.

Behaviour:
Main control (outputs listed as alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch):
- 0110011 R-type: 10, 1, 0, 0, 0, 0, 0.
- 0010011 I-ALU: 11, 1, 0, 0, 1, 0, 0.
- 0000011 load: 00, 1, 1, 0, 1, 1, 0.
- 0100011 store: 00, 0, 0, 1, 1, 0, 0.
- 1100011 branch: 01, 0, 0, 0, 0, 0, 1.
- Any other opcode: all outputs 0 (alu_op=00). No side effects.

alu_ctrl codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
- 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
- 1000 SLT, 1001 SLTU.

alu_ctrl decode by alu_op:
- 00 → ADD.
- 01 → SUB.
- 10 (R-type), by funct3:
  - 000 → SUB if funct7[5], else ADD;
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR;
  - 101 → SRA if funct7[5], else SRL;
  - 110 → OR; 111 → AND.
- 11 (I-type): same as 10, except funct3=000 is always ADD, so addi never subtracts. funct3=101 still uses funct7[5] (srai vs srli).

ALU datapath:
- Operand B = alu_src ? imm : rs2_data.
- ADD/SUB wrap modulo 2^32; no overflow or carry outputs.
- Shifts use B[4:0] only. SRA is arithmetic, replicating A[31].
- SLT compares signed, SLTU compares unsigned; result is 32'd1 or 32'd0.
- An unlisted alu_ctrl code (1010–1111) gives result 0; zero is then 1.
- zero = (alu_result == 32'd0).

branch_taken:
- Equals branch AND condition.
- Condition by funct3: 000 BEQ → zero; 001 BNE → !zero; any other funct3 → 0.
- Forced 0 when branch=0.

Timing and reset:
- All decode, ALU and branch outputs are purely combinational: zero-cycle latency, no state, independent of clk and rst.
- result_q and zero_q capture alu_result and zero on every rising clk (1-cycle latency).
- rst=1 asynchronously forces result_q=0 and zero_q=0, immediately and regardless of clk; they hold while rst is high.
- Capture resumes on the first rising edge after rst deasserts.
- Combinational outputs keep tracking inputs during reset.

Test Plan:
- R-type sub: opcode=0110011, f3=000, f7=0100000, rs1=7, rs2=7 → alu_ctrl=0110, alu_result=0, zero=1, reg_write=1, alu_src=0. Next rising edge → result_q=0, zero_q=1.
- addi with imm=-1 (0xFFFFFFFF) and f7 bits=1111111, rs1=5 → alu_op=11, alu_ctrl=0010 (not SUB), alu_result=4, alu_src=1.
- Load: opcode=0000011, rs1=0x100, imm=8 → alu_result=0x108, mem_read=1, mem_to_reg=1, reg_write=1. Store: opcode=0100011 → mem_write=1, reg_write=0.
- Branches: BEQ with rs1=rs2=3 → branch=1, zero=1, branch_taken=1. BEQ with 3 vs 4 → branch_taken=0. BNE with 3 vs 4 → branch_taken=1. Any non-branch opcode with zero=1 → branch_taken=0.
- Shift and compare:
  - SRA: rs1=0x80000000, rs2=4 → 0xF8000000.
  - SRL, same operands → 0x08000000.
  - SLT: -1 vs 1 → 1.
  - SLTU: 0xFFFFFFFF vs 1 → 0.
  - Shift amount: rs2=0x24 gives a shift of 4.
- Reset: drive alu_result=0x1234 and clock it into result_q; assert rst between edges → result_q=0 and zero_q=0 without a clock edge. Unknown opcode 1111111 → all controls 0, alu_ctrl=0010.
